// File: rtl/updown_mod_counter.sv
// updown_mod_counter: synchronous up/down modulo-MODULUS counter with load, clear, terminal count and one-shot stop
// Define COUNTER_GRAY_OUT_EN to add count_gray, a registered binary-reflected Gray copy of count.
module updown_mod_counter #(
    parameter int WIDTH = 8,
    parameter longint unsigned MODULUS = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done
`ifdef COUNTER_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] count_gray
`endif
);
    typedef enum logic {RUN, DONE} state_t;
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    state_t state, state_nx;
    logic [WIDTH-1:0] count_nx;
    logic wrap_nx, stop;
    assign tc = up ? (count == MAX) : (count == '0);
    assign stop = tc && oneshot;
    always_comb begin
        count_nx = count;
        state_nx = state;
        wrap_nx = 1'b0;
        if (clear) begin
            count_nx = '0;
            state_nx = RUN;
        end else if (load) begin
            count_nx = (64'(load_val) >= 64'(MODULUS)) ? MAX : load_val;
            state_nx = RUN;
        end else if (en && state == RUN) begin
            wrap_nx = tc;
            state_nx = stop ? DONE : RUN;
            count_nx = stop ? count : tc ? (up ? '0 : MAX) : (up ? count + 1'b1 : count - 1'b1);
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            count <= '0;
            state <= RUN;
            wrap <= 1'b0;
            done <= 1'b0;
        end else begin
            count <= count_nx;
            state <= state_nx;
            wrap <= wrap_nx;
            done <= (state_nx == DONE);
        end
`ifdef COUNTER_GRAY_OUT_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            count_gray <= '0;
        else
            count_gray <= count_nx ^ (count_nx >> 1);
`endif
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: randomized and directed checks of updown_mod_counter against a modulo-arithmetic model
module tb_updown_mod_counter;
    localparam int W = 4;
    localparam int M = 10;
    logic clk = 0, reset_n = 0, en = 0, up = 1, load = 0, clear = 0, oneshot = 0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic tc, wrap, done;
`ifdef COUNTER_GRAY_OUT_EN
    logic [W-1:0] count_gray;
`endif
    int errors = 0, checks = 0;
    int m_count = 0;
    bit m_wrap = 0, m_done = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .clear(clear), .oneshot(oneshot), .count(count), .tc(tc), .wrap(wrap), .done(done)
`ifdef COUNTER_GRAY_OUT_EN
        , .count_gray(count_gray)
`endif
    );

    function automatic bit m_tc();
        return up ? (m_count == M - 1) : (m_count == 0);
    endfunction

    // one rising edge applied to both the DUT and the model; returns 1 ns after the edge
    task automatic step();
        bit t = m_tc();
        @(posedge clk);
        if (clear) begin
            m_count = 0; m_wrap = 0; m_done = 0;
        end else if (load) begin
            m_count = (load_val >= M) ? M - 1 : int'(load_val); m_wrap = 0; m_done = 0;
        end else if (en && !m_done) begin
            m_wrap = t;
            if (t && oneshot) m_done = 1;
            else m_count = (m_count + (up ? 1 : M - 1)) % M;
        end else m_wrap = 0;
        #1;
    endtask

    task automatic idle();
        en = 0; load = 0; clear = 0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (count !== '0 || wrap !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d wrap=%b done=%b tc=%b, want 0 0 0 0", count, wrap, done, tc);
        end
        reset_n = 1;
    endtask

    task automatic test_count_up();
        up = 1; oneshot = 0; en = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (count !== W'((i + 1) % M) || wrap !== (i == 9) || tc !== (((i + 1) % M) == M - 1) || done !== 1'b0) begin
                errors++;
                $display("FAIL up[%0d]: count=%0d wrap=%b tc=%b done=%b, want %0d %b %b 0",
                         i, count, wrap, tc, done, (i + 1) % M, i == 9, ((i + 1) % M) == M - 1);
            end
        end
        idle();
    endtask

    task automatic test_count_down();
        clear = 1; step(); idle();
        up = 0; en = 1;
        for (int i = 0; i < 11; i++) begin
            step();
            checks++;
            if (count !== W'((M - (i + 1) % M) % M) || wrap !== (i == 0 || i == 10)) begin
                errors++;
                $display("FAIL down[%0d]: count=%0d wrap=%b, want %0d %b",
                         i, count, wrap, (M - (i + 1) % M) % M, i == 0 || i == 10);
            end
        end
        idle();
        up = 1;
    endtask

    task automatic test_load_clear();
        load = 1; load_val = 4'd13; step();
        checks++;
        if (count !== 4'd9 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp: count=%0d wrap=%b, want 9 0", count, wrap);
        end
        load_val = 4'd4; clear = 1; en = 1; step();
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL clear_wins: count=%0d, want 0", count);
        end
        clear = 0; step();
        checks++;
        if (count !== 4'd4) begin
            errors++;
            $display("FAIL load_over_en: count=%0d, want 4", count);
        end
        idle();
    endtask

    task automatic test_oneshot();
        int exp_c[6] = '{8, 9, 9, 9, 2, 3};
        bit exp_d[6] = '{0, 0, 1, 1, 0, 0};
        bit exp_w[6] = '{0, 0, 1, 0, 0, 0};
        load = 1; load_val = 4'd7; step(); load = 0;
        oneshot = 1; up = 1; en = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin load = 1; load_val = 4'd2; end
            if (i == 5) load = 0;
            step();
            checks++;
            if (count !== W'(exp_c[i]) || done !== exp_d[i] || wrap !== exp_w[i]) begin
                errors++;
                $display("FAIL oneshot[%0d]: count=%0d done=%b wrap=%b, want %0d %b %b",
                         i, count, done, wrap, exp_c[i], exp_d[i], exp_w[i]);
            end
        end
        idle();
        oneshot = 0;
    endtask

    task automatic test_async_reset();
        load = 1; load_val = 4'd5; step(); idle();
        #3 reset_n = 0;
        #1;
        checks++;
        if (count !== '0 || wrap !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d wrap=%b done=%b, want 0 0 0", count, wrap, done);
        end
        m_count = 0; m_wrap = 0; m_done = 0;
        @(negedge clk) reset_n = 1;
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clear = ($urandom_range(0, 19) == 0);
            load = ($urandom_range(0, 14) == 0);
            load_val = W'($urandom_range(0, 15));
            en = ($urandom_range(0, 3) != 0);
            up = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) oneshot = ~oneshot;
            step();
            checks++;
            if (count !== W'(m_count) || wrap !== m_wrap || done !== m_done || tc !== m_tc()) begin
                errors++;
                $display("FAIL random[%0d]: count=%0d wrap=%b done=%b tc=%b, want %0d %b %b %b",
                         i, count, wrap, done, tc, m_count, m_wrap, m_done, m_tc());
            end
`ifdef COUNTER_GRAY_OUT_EN
            checks++;
            if (count_gray !== W'(m_count ^ (m_count >> 1))) begin
                errors++;
                $display("FAIL gray[%0d]: count_gray=%b, want %b", i, count_gray, W'(m_count ^ (m_count >> 1)));
            end
`endif
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clear();
        test_oneshot();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down modulo-N counter; successor to the fixed 3-bit toggle-chain counter. All flops share one clock, so there are no ripple delays or derived clocks. Adds direction control, enable, parallel load, synchronous clear, a terminal-count flag, a wrap pulse and a one-shot (stop-at-terminal) mode. It serves as the general counting primitive for timers, address sequencers and divide-by-N tick generators.

## Interface
- WIDTH, 8, counter width in bits; legal range 2–32.
- MODULUS, 256, count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 counts up, 0 counts down. Sampled every enabled cycle.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value used by load.
- clear  in  1  synchronous clear to 0.
- oneshot  in  1  mode: 0 is free-running wrap, 1 stops at terminal.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal count: combinational, (up && count==MODULUS-1) || (!up && count==0).
- wrap  out  1  registered one-cycle pulse; marks a wrap in free-running mode or a stop in one-shot mode.
- done  out  1  registered; set while the counter is halted in the one-shot DONE state.

## Operation
- Reset (reset_n=0, asynchronous): count=0, wrap=0, done=0, state=RUN.
- States:
  - RUN: normal counting.
  - DONE: one-shot halt. Only reachable when oneshot=1.
- Per-edge priority: clear > load > en. Lower-priority inputs are ignored in the same cycle.
- clear=1: count←0, wrap←0, state←RUN, done←0.
- load=1: count←load_val, or MODULUS-1 if load_val≥MODULUS (clamp); wrap←0, state←RUN, done←0.
- en=1 in RUN, tc=0: count ±1 in direction up; wrap←0.
- en=1 in RUN, tc=1, oneshot=0: up wraps MODULUS-1→0, down wraps 0→MODULUS-1; wrap←1.
- en=1 in RUN, tc=1, oneshot=1: count holds; state←DONE; done←1; wrap←1.
- DONE: count holds regardless of en/up; leaves only via clear, load or reset.
- en=0: count holds; wrap←0.
- Arithmetic is modulo MODULUS, never modulo 2^WIDTH; count never leaves 0..MODULUS-1.
- Changing oneshot while in DONE has no effect until clear/load.
- Reversing up at tc: tc is re-evaluated for the new direction in the same cycle. Example: count=MODULUS-1 with up=0 decrements normally.

## Timing
- Latency from clear/load/en to count: one edge.
- wrap is high for exactly the one cycle following the wrapping/stopping edge, i.e. coincident with the new count value.
- Continuous en in free-running mode: wrap pulses once every MODULUS cycles.
- tc has zero latency: combinational from count and up, so it can gate the same-cycle en of a cascaded stage.
- done rises on the stopping edge and stays high until the clear/load edge.
- Reset assertion mid-count: outputs go to reset values immediately, without waiting for clk. Deassertion is synchronised externally; the block assumes it is clean relative to clk.

## Configuration
- COUNTER_GRAY_OUT_EN defined:
  - adds output count_gray (WIDTH bits) = registered binary-to-Gray of the next count, updated on the same edge as count, so it is aligned with count;
  - reset value is 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.
- Gray is a plain binary-reflected conversion. Adjacency across the wrap is guaranteed only when MODULUS is a power of two.

## Test plan
- WIDTH=4, MODULUS=10, up=1, en=1 from reset for 12 cycles -> count 0,1..9,0,1; wrap high only on the cycle count=0 after 9; tc high when count=9.
- MODULUS=10, up=0 from reset -> first edge gives count=9 with wrap=1; then 8,7,…
- load=1, load_val=13, clear=0, MODULUS=10 -> count=9. Same cycle with clear=1 -> count=0 (clear wins).
- oneshot=1, load 7, up=1, en=1, MODULUS=10 -> count 8, 9, then holds 9; done=1; one wrap pulse. Further en keeps count=9; load 2 -> done=0, counting resumes at 3.
- Assert reset_n=0 between clock edges at count=5 -> count=0, wrap=0, done=0 before the next clk edge.
- With COUNTER_GRAY_OUT_EN, WIDTH=3, MODULUS=8, count up -> count_gray sequence 000,001,011,010,110,111,101,100,000; exactly one bit changes per step.
